// File: rtl/epc_bus_pkg.sv
// Shared constants and types for the EPC peripheral bus controller.
package epc_bus_pkg;

  localparam logic [5:0] LCD_DATA_ADDR    = 6'h00;
  localparam logic [5:0] LCD_CONTROL_ADDR = 6'h04;
  localparam logic [5:0] UART_DATA_ADDR   = 6'h08;
  localparam logic [5:0] UART_STATUS_ADDR = 6'h0C;

  localparam int TIMEOUT_CYCLES_DEF = 1023;
  localparam int TW_DEF             = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_LCD_WAIT,
    ST_UART_WAIT,
    ST_RESPOND,
    ST_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    TGT_LCD,
    TGT_UART,
    TGT_STATUS,
    TGT_NONE
  } target_e;

  function automatic target_e decode_addr(input logic [5:0] addr);
    case (addr)
      LCD_DATA_ADDR, LCD_CONTROL_ADDR: return TGT_LCD;
      UART_DATA_ADDR:                  return TGT_UART;
      UART_STATUS_ADDR:                return TGT_STATUS;
      default:                         return TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/epc_strobe_sync.sv
// Two-flop synchronisers for the EPC strobes plus access-start edge detect.
module epc_strobe_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ncs_i,
  input  logic nrd_i,
  input  logic nwr_i,
  output logic active_o,
  output logic start_o,
  output logic released_o,
  output logic wr_o
);

  // bit order {ncs, nrd, nwr}; reset to the inactive (high) level
  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic       active_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q   <= 3'b111;
      sync_q   <= 3'b111;
      active_q <= 1'b0;
    end else begin
      meta_q   <= {ncs_i, nrd_i, nwr_i};
      sync_q   <= meta_q;
      active_q <= active_o;
    end
  end

  assign active_o   = !sync_q[2] && (!sync_q[1] || !sync_q[0]);
  assign start_o    = active_o && !active_q;
  assign released_o = sync_q[1] && sync_q[0];
  assign wr_o       = !sync_q[0];

endmodule

// File: rtl/epc_bus_controller.sv
// Transaction engine between the MicroBlaze EPC pins and the LCD / UART slaves.
//
//  state        | meaning
//  ST_IDLE      | waiting for a synced strobe rising edge
//  ST_DECODE    | request pulse out; local accesses (status, unmapped) resolve here
//  ST_LCD_WAIT  | waiting for lcd_ack or timeout
//  ST_UART_WAIT | waiting for uart_ack or timeout
//  ST_RESPOND   | first Rdy cycle
//  ST_RELEASE   | Rdy held until both synced strobes deassert
module epc_bus_controller
  import epc_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TW             = TW_DEF
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       epc_nCS,
  input  logic [5:0] epc_Addr,
  input  logic       epc_nRD,
  input  logic       epc_nWR,
  input  logic [7:0] epc_DataO,
  output logic [7:0] epc_DataI,
  output logic       epc_Rdy,
  output logic       slv_wr,
  output logic [7:0] slv_wdata,
  output logic       lcd_req,
  output logic       lcd_rs,
  input  logic       lcd_ack,
  input  logic [7:0] lcd_rdata,
  output logic       uart_req,
  input  logic       uart_ack,
  input  logic [7:0] uart_rdata,
  input  logic [7:0] uart_status,
  output logic       err_timeout,
  output logic       err_decode,
  input  logic       err_clear
);

  logic active, start, released, wr_sync;

  epc_strobe_sync u_sync (
    .clk_i      (clk),
    .rst_ni     (nRst),
    .ncs_i      (epc_nCS),
    .nrd_i      (epc_nRD),
    .nwr_i      (epc_nWR),
    .active_o   (active),
    .start_o    (start),
    .released_o (released),
    .wr_o       (wr_sync)
  );

  state_e        state_q;
  target_e       tgt_q;
  logic [TW-1:0] cnt_q;
  logic          abort_q;
  logic [7:0]    data_q, wdata_q;
  logic          rdy_q, wr_q, lcd_req_q, uart_req_q, rs_q, err_to_q, err_dec_q;

  target_e    tgt_new;
  logic       slv_ack, abort_now, timed_out;
  logic [7:0] slv_rdata;

  always_comb begin
    tgt_new   = decode_addr(epc_Addr);
    slv_ack   = (state_q == ST_LCD_WAIT  && lcd_ack) ||
                (state_q == ST_UART_WAIT && uart_ack);
    slv_rdata = (state_q == ST_LCD_WAIT) ? lcd_rdata : uart_rdata;
    abort_now = abort_q || !active;
    timed_out = (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      tgt_q      <= TGT_NONE;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      data_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rdy_q      <= 1'b0;
      wr_q       <= 1'b0;
      lcd_req_q  <= 1'b0;
      uart_req_q <= 1'b0;
      rs_q       <= 1'b0;
      err_to_q   <= 1'b0;
      err_dec_q  <= 1'b0;
    end else begin
      // error sets below are later assignments, so they beat a same-cycle clear
      if (err_clear) begin
        err_to_q  <= 1'b0;
        err_dec_q <= 1'b0;
      end
      lcd_req_q  <= 1'b0;
      uart_req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tgt_q      <= tgt_new;
            wdata_q    <= epc_DataO;
            wr_q       <= wr_sync;
            rs_q       <= (epc_Addr == LCD_DATA_ADDR);
            lcd_req_q  <= (tgt_new == TGT_LCD);
            uart_req_q <= (tgt_new == TGT_UART);
            state_q    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          cnt_q   <= '0;
          abort_q <= !active;
          case (tgt_q)
            TGT_LCD:  state_q <= ST_LCD_WAIT;
            TGT_UART: state_q <= ST_UART_WAIT;
            TGT_STATUS: begin
              if (!wr_q) data_q <= uart_status;
              rdy_q   <= 1'b1;
              state_q <= ST_RESPOND;
            end
            default: begin
              data_q    <= 8'h00;
              err_dec_q <= 1'b1;
              rdy_q     <= 1'b1;
              state_q   <= ST_RESPOND;
            end
          endcase
        end
        ST_LCD_WAIT, ST_UART_WAIT: begin
          if (slv_ack || timed_out) begin
            if (slv_ack) begin
              if (!wr_q) data_q <= slv_rdata;
            end else begin
              data_q   <= 8'hFF;
              err_to_q <= 1'b1;
            end
            rdy_q   <= !abort_now;
            state_q <= abort_now ? ST_IDLE : ST_RESPOND;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            abort_q <= abort_now;
          end
        end
        ST_RESPOND, ST_RELEASE: begin
          if (released) begin
            rdy_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_RELEASE;
          end
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign epc_DataI   = data_q;
  assign epc_Rdy     = rdy_q;
  assign slv_wr      = wr_q;
  assign slv_wdata   = wdata_q;
  assign lcd_req     = lcd_req_q;
  assign lcd_rs      = rs_q;
  assign uart_req    = uart_req_q;
  assign err_timeout = err_to_q;
  assign err_decode  = err_dec_q;

endmodule
